// File: rtl/branch_pred_ctrl_pkg.sv
// Shared encodings, defaults and counter arithmetic for the branch predictor controller.
package branch_pred_ctrl_pkg;

  localparam int DEF_IDX_W    = 4;
  localparam int DEF_UQ_DEPTH = 4;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  typedef enum logic {
    ST_NORMAL      = 1'b0,
    ST_FORCE_DRAIN = 1'b1
  } state_e;

  // Saturating 2-bit counter step; holds at STRONG_T / STRONG_NT instead of wrapping.
  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    if (taken) begin
      r = (c == STRONG_T) ? c : c + 2'd1;
    end else begin
      r = (c == STRONG_NT) ? c : c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_pred_ctrl_upd_fifo.sv
// Update queue: circular FIFO with power-of-two depth; head entry is always visible.
module bpred_upd_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
    end else begin
      mem_d = mem_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch predictor: table of 2-bit saturating counters, lookups take priority over
// draining a queue of resolved-branch updates; a full queue forces a drain phase.
module branch_pred_ctrl
  import branch_pred_ctrl_pkg::*;
#(
  parameter int IDX_W    = DEF_IDX_W,
  parameter int UQ_DEPTH = DEF_UQ_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lookup_valid,
  input  logic [IDX_W-1:0]            lookup_idx,
  output logic                        lookup_ready,
  output logic                        pred_valid,
  output logic                        pred_taken,
  output logic [IDX_W-1:0]            pred_idx,
  input  logic                        upd_valid,
  input  logic [IDX_W-1:0]            upd_idx,
  input  logic                        upd_taken,
  output logic                        upd_ready,
  output logic [$clog2(UQ_DEPTH):0]   uq_count
);

  localparam int            ENTRIES  = 1 << IDX_W;
  localparam int            CW       = $clog2(UQ_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(UQ_DEPTH);

  state_e                   state_q, state_d;
  logic [ENTRIES-1:0][1:0]  table_q, table_d;
  logic                     pred_valid_q, pred_valid_d;
  logic                     pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0]         pred_idx_q, pred_idx_d;

  logic                     lookup_fire_s;
  logic                     upd_fire_s;
  logic                     pop_s;
  logic [CW-1:0]            cnt_nxt_s;
  logic [IDX_W:0]           head_s;

  bpred_upd_fifo #(
    .W     (IDX_W + 1),
    .DEPTH (UQ_DEPTH)
  ) u_upd_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (upd_fire_s),
    .push_data_i ({upd_idx, upd_taken}),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .count_o     (uq_count)
  );

  // Handshakes depend only on state and queue occupancy; the single table port goes to
  // a lookup when one is accepted, otherwise to the queue head.
  always_comb begin
    lookup_ready  = (state_q == ST_NORMAL);
    upd_ready     = (state_q == ST_NORMAL) && (uq_count < FULL_CNT);
    lookup_fire_s = lookup_valid && lookup_ready;
    upd_fire_s    = upd_valid && upd_ready;
    pop_s         = (uq_count != CW'(0)) && !lookup_fire_s;
    cnt_nxt_s     = uq_count + CW'(upd_fire_s) - CW'(pop_s);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: begin
        if (cnt_nxt_s == FULL_CNT) state_d = ST_FORCE_DRAIN;
        else                       state_d = ST_NORMAL;
      end
      ST_FORCE_DRAIN: begin
        if (cnt_nxt_s == CW'(0)) state_d = ST_NORMAL;
        else                     state_d = ST_FORCE_DRAIN;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    table_d      = table_q;
    pred_valid_d = lookup_fire_s;
    pred_taken_d = pred_taken_q;
    pred_idx_d   = pred_idx_q;
    if (pop_s) begin
      table_d[head_s[IDX_W:1]] = sat_update(table_q[head_s[IDX_W:1]], head_s[0]);
    end else begin
      table_d = table_q;
    end
    if (lookup_fire_s) begin
      pred_taken_d = table_q[lookup_idx][1];
      pred_idx_d   = lookup_idx;
    end else begin
      pred_taken_d = pred_taken_q;
      pred_idx_d   = pred_idx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_NORMAL;
      table_q      <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      table_q      <= table_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_idx_q   <= pred_idx_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_idx   = pred_idx_q;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed self-checking bench for branch_pred_ctrl with hand-computed expectations.
module tb_branch_pred_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lookup_valid = 1'b0;
  logic [3:0] lookup_idx = 4'd0;
  logic       lookup_ready;
  logic       pred_valid;
  logic       pred_taken;
  logic [3:0] pred_idx;
  logic       upd_valid = 1'b0;
  logic [3:0] upd_idx = 4'd0;
  logic       upd_taken = 1'b0;
  logic       upd_ready;
  logic [2:0] uq_count;

  int n_vec = 0;
  int n_miscmp = 0;

  branch_pred_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_idx   (lookup_idx),
    .lookup_ready (lookup_ready),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_idx     (pred_idx),
    .upd_valid    (upd_valid),
    .upd_idx      (upd_idx),
    .upd_taken    (upd_taken),
    .upd_ready    (upd_ready),
    .uq_count     (uq_count)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [3:0] idx, input logic exp_taken, input string tag);
    lookup_valid = 1'b1;
    lookup_idx   = idx;
    check_vec({tag, "_lrdy"}, 32'(lookup_ready), 32'd1);
    cyc();
    lookup_valid = 1'b0;
    check_vec({tag, "_pvalid"}, 32'(pred_valid), 32'd1);
    check_vec({tag, "_ptaken"}, 32'(pred_taken), 32'(exp_taken));
    check_vec({tag, "_pidx"},   32'(pred_idx),   32'(idx));
  endtask

  task automatic do_update(input logic [3:0] idx, input logic taken);
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_taken = taken;
    check_vec("upd_rdy", 32'(upd_ready), 32'd1);
    cyc();
    upd_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (uq_count == 3'd0) break;
      cyc();
    end
    check_vec(tag, 32'(uq_count), 32'd0);
  endtask

  initial begin
    // Reset state
    cyc();
    check_vec("rst_uq",    32'(uq_count),     32'd0);
    check_vec("rst_pv",    32'(pred_valid),   32'd0);
    check_vec("rst_pt",    32'(pred_taken),   32'd0);
    check_vec("rst_pidx",  32'(pred_idx),     32'd0);
    check_vec("rst_lrdy",  32'(lookup_ready), 32'd1);
    check_vec("rst_urdy",  32'(upd_ready),    32'd1);
    rst = 1'b0;
    cyc();

    // First lookup after reset, then pred_valid must drop
    do_lookup(4'd3, 1'b0, "lk3");
    cyc();
    check_vec("pv_drop", 32'(pred_valid), 32'd0);

    // Not-taken on a strongly-not-taken counter must not wrap
    do_update(4'd0, 1'b0);
    wait_empty("drain0");
    do_lookup(4'd0, 1'b0, "lk0_sat");

    // Upper saturation on idx 5: 3xT -> 11, T stays 11, NT -> 10, NT -> 01, T -> 10
    do_update(4'd5, 1'b1);
    do_update(4'd5, 1'b1);
    do_update(4'd5, 1'b1);
    wait_empty("drain5a");
    do_lookup(4'd5, 1'b1, "lk5_3t");
    do_update(4'd5, 1'b1);
    do_update(4'd5, 1'b0);
    wait_empty("drain5b");
    do_lookup(4'd5, 1'b1, "lk5_10");
    do_update(4'd5, 1'b0);
    wait_empty("drain5c");
    do_lookup(4'd5, 1'b0, "lk5_01");
    do_update(4'd5, 1'b1);
    wait_empty("drain5d");
    do_lookup(4'd5, 1'b1, "lk5_back10");

    // Fill the queue with lookups held high, then force drain for 4 cycles
    lookup_valid = 1'b1;
    lookup_idx   = 4'd7;
    for (int i = 0; i < 4; i++) begin
      upd_valid = 1'b1;
      upd_idx   = 4'd2;
      upd_taken = 1'b1;
      check_vec("fill_urdy", 32'(upd_ready), 32'd1);
      cyc();
    end
    upd_valid = 1'b0;
    check_vec("fill_pv", 32'(pred_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_vec("fd_uq",   32'(uq_count),     32'(4 - i));
      check_vec("fd_lrdy", 32'(lookup_ready), 32'd0);
      check_vec("fd_urdy", 32'(upd_ready),    32'd0);
      cyc();
      if (i == 0) check_vec("fd_pv", 32'(pred_valid), 32'd0);
    end
    check_vec("fd_end_uq",   32'(uq_count),     32'd0);
    check_vec("fd_end_lrdy", 32'(lookup_ready), 32'd1);
    check_vec("fd_end_urdy", 32'(upd_ready),    32'd1);
    lookup_valid = 1'b0;
    do_lookup(4'd2, 1'b1, "lk2_full");

    // Continuous push/drain, alternating idx 1 (all T) and idx 9 (NT,NT,T,T,T)
    for (int i = 0; i < 10; i++) begin
      upd_valid = 1'b1;
      upd_idx   = (i % 2 == 0) ? 4'd1 : 4'd9;
      upd_taken = (i % 2 == 0) ? 1'b1 : (i >= 5);
      check_vec("alt_urdy", 32'(upd_ready), 32'd1);
      cyc();
      check_vec("alt_uq", 32'(uq_count), 32'd1);
    end
    upd_valid = 1'b0;
    wait_empty("drain_alt");
    do_lookup(4'd1, 1'b1, "lk1_alt");
    do_lookup(4'd9, 1'b1, "lk9_alt");

    // Reset mid-drain: two queued to idx 12 behind held lookups, one applied, then reset
    lookup_valid = 1'b1;
    lookup_idx   = 4'd13;
    do_update(4'd12, 1'b1);
    do_update(4'd12, 1'b1);
    check_vec("pre_rst_uq", 32'(uq_count), 32'd2);
    lookup_valid = 1'b0;
    cyc();
    check_vec("mid_drain_uq", 32'(uq_count), 32'd1);
    rst = 1'b1;
    #1;
    check_vec("mrst_uq",   32'(uq_count),   32'd0);
    check_vec("mrst_pv",   32'(pred_valid), 32'd0);
    check_vec("mrst_pidx", 32'(pred_idx),   32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    check_vec("post_rst_uq", 32'(uq_count), 32'd0);
    do_lookup(4'd12, 1'b0, "lk12_rst");
    do_lookup(4'd5,  1'b0, "lk5_rst");
    do_lookup(4'd2,  1'b0, "lk2_rst");
    do_lookup(4'd1,  1'b0, "lk1_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
